// File: rtl/san_irq_capture_if.sv
// -----------------------------------------------------------------------------
// san_irq_capture_if
//   Register-access bundle between the AXI4-Lite slave front end and the
//   interrupt capture block. The front end has already decoded the AXI
//   handshakes into single-cycle write/read strobes and word indices.
//
//   slv_reg_wren  : register write strobe, one cycle per write
//   axi_awaddr    : write word index (3 bits)
//   S_AXI_WDATA   : write data (32 bits)
//   slv_reg_rden  : register read strobe, one cycle per read
//   axi_araddr    : read word index (3 bits)
//   reg_data_out  : registered read data (32 bits)
//
//   master : AXI front end (drives strobes, addresses, write data)
//   slave  : register block (drives read data)
// -----------------------------------------------------------------------------
interface san_irq_capture_if;
  logic        slv_reg_wren;
  logic [2:0]  axi_awaddr;
  logic [31:0] S_AXI_WDATA;
  logic        slv_reg_rden;
  logic [2:0]  axi_araddr;
  logic [31:0] reg_data_out;

  modport master (
    output slv_reg_wren,
    output axi_awaddr,
    output S_AXI_WDATA,
    output slv_reg_rden,
    output axi_araddr,
    input  reg_data_out
  );

  modport slave (
    input  slv_reg_wren,
    input  axi_awaddr,
    input  S_AXI_WDATA,
    input  slv_reg_rden,
    input  axi_araddr,
    output reg_data_out
  );
endinterface

// File: rtl/san_irq_capture.sv
// -----------------------------------------------------------------------------
// san_irq_capture
//   CPU-side capture of the counter block's EXT_IRQ pulse. Rising edges of
//   EXT_IRQ (while enabled) set a sticky PENDING flag that drives a level
//   interrupt to the PS until software clears it with a write-one-to-clear.
//   The block also keeps an accepted-event count, a saturating missed-event
//   count (edges that arrived while PENDING was already set), the timestamp
//   of the last edge that set PENDING, and a free-running cycle counter.
//
//   Register map (word index):
//     0 CTRL    RW  bit0 EN, bit1 CLR (write-1 pulse, reads 0)
//     1 STATUS  W1C bit0 PENDING, bit1 OVF
//     2 EVT_CNT RO  accepted edges, wraps
//     3 MISSED  RO  missed edges, saturating, zero-extended
//     4 LAST_TS RO  TIME captured at the last edge that set PENDING
//     5 TIME    RO  free-running cycle counter, wraps
//     6,7           read 0, writes ignored
//
//   Ports:
//     S_AXI_ACLK    : single clock, rising edge
//     S_AXI_ARESET  : synchronous active-high reset
//     EXT_IRQ       : interrupt pulse, same clock domain
//     bus           : register access bundle (slave side)
//     IRQ_OUT       : registered level interrupt, EN & PENDING
//     IRQ_EVENT_CNT : debug mirror of EVT_CNT
// -----------------------------------------------------------------------------
module san_irq_capture #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int MISSED_W           = 16
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic                          EXT_IRQ,
  san_irq_capture_if.slave              bus,
  output logic                          IRQ_OUT,
  output logic [C_S_AXI_DATA_WIDTH-1:0] IRQ_EVENT_CNT
);

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_EVT_CNT = 3'd2;
  localparam logic [2:0] ADDR_MISSED  = 3'd3;
  localparam logic [2:0] ADDR_LAST_TS = 3'd4;
  localparam logic [2:0] ADDR_TIME    = 3'd5;

  // Saturating increment for the MISSED counter: holds at all ones.
  function automatic logic [MISSED_W-1:0] sat_inc(input logic [MISSED_W-1:0] v);
    logic [MISSED_W-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + one;
    end
  endfunction

  // State registers
  logic                          ext_irq_d_r;
  logic                          en_r;
  logic                          pending_r;
  logic                          ovf_r;
  logic [31:0]                   evt_cnt_r;
  logic [MISSED_W-1:0]           missed_r;
  logic [31:0]                   last_ts_r;
  logic [31:0]                   time_r;
  logic                          irq_out_r;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_r;

  // Next-state / decode signals
  logic                          wr_ctrl_s;
  logic                          wr_status_s;
  logic                          clr_s;
  logic                          pend_clr_s;
  logic                          ovf_clr_s;
  logic                          edge_s;
  logic                          accept_s;
  logic                          first_s;
  logic                          miss_s;
  logic                          en_next_s;
  logic                          pending_next_s;
  logic                          ovf_next_s;
  logic [31:0]                   evt_base_s;
  logic [31:0]                   evt_next_s;
  logic [MISSED_W-1:0]           missed_base_s;
  logic [MISSED_W-1:0]           missed_next_s;
  logic [31:0]                   last_ts_next_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_s;
  logic                          unused_wdata_s;

  // Only the two low write-data bits carry meaning in this register map.
  assign unused_wdata_s = ^bus.S_AXI_WDATA[31:2];

  // Write decode, edge detect and next-state computation for all counters.
  always_comb begin
    wr_ctrl_s   = bus.slv_reg_wren & (bus.axi_awaddr == ADDR_CTRL);
    wr_status_s = bus.slv_reg_wren & (bus.axi_awaddr == ADDR_STATUS);
    clr_s       = wr_ctrl_s & bus.S_AXI_WDATA[1];
    pend_clr_s  = wr_status_s & bus.S_AXI_WDATA[0];
    ovf_clr_s   = wr_status_s & bus.S_AXI_WDATA[1];

    // EN gates with its pre-write value, so a write enabling EN cannot
    // accept an edge in the same cycle.
    edge_s   = EXT_IRQ & ~ext_irq_d_r;
    accept_s = edge_s & en_r;

    // An edge landing on a cycle that W1C-clears PENDING counts as a fresh
    // event, not a missed one: set wins over clear.
    first_s = accept_s & (~pending_r | pend_clr_s);
    miss_s  = accept_s & pending_r & ~pend_clr_s;

    // CLR zeroes the counters first; a same-cycle edge then lands on zero.
    if (clr_s) begin
      evt_base_s    = 32'd0;
      missed_base_s = '0;
    end else begin
      evt_base_s    = evt_cnt_r;
      missed_base_s = missed_r;
    end

    evt_next_s = evt_base_s + {31'd0, accept_s};

    if (miss_s) begin
      missed_next_s = sat_inc(missed_base_s);
    end else begin
      missed_next_s = missed_base_s;
    end

    if (first_s) begin
      last_ts_next_s = time_r;
    end else begin
      last_ts_next_s = last_ts_r;
    end

    if (wr_ctrl_s) begin
      en_next_s = bus.S_AXI_WDATA[0];
    end else begin
      en_next_s = en_r;
    end

    pending_next_s = (pending_r & ~pend_clr_s) | accept_s;
    // OVF is raised on the missed edge that leaves MISSED at all ones.
    ovf_next_s     = (ovf_r & ~ovf_clr_s) | (miss_s & (&missed_next_s));
  end

  // Read mux over the current (pre-update) register values.
  always_comb begin
    rdata_s = '0;
    case (bus.axi_araddr)
      ADDR_CTRL:    rdata_s[0]          = en_r;
      ADDR_STATUS:  rdata_s[1:0]        = {ovf_r, pending_r};
      ADDR_EVT_CNT: rdata_s[31:0]       = evt_cnt_r;
      ADDR_MISSED:  rdata_s[MISSED_W-1:0] = missed_r;
      ADDR_LAST_TS: rdata_s[31:0]       = last_ts_r;
      ADDR_TIME:    rdata_s[31:0]       = time_r;
      default:      rdata_s             = '0;
    endcase
  end

  // Control, status and counter registers.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      ext_irq_d_r <= 1'b0;
      en_r        <= 1'b0;
      pending_r   <= 1'b0;
      ovf_r       <= 1'b0;
      evt_cnt_r   <= 32'd0;
      missed_r    <= '0;
      last_ts_r   <= 32'd0;
      time_r      <= 32'd0;
    end else begin
      ext_irq_d_r <= EXT_IRQ;
      en_r        <= en_next_s;
      pending_r   <= pending_next_s;
      ovf_r       <= ovf_next_s;
      evt_cnt_r   <= evt_next_s;
      missed_r    <= missed_next_s;
      last_ts_r   <= last_ts_next_s;
      time_r      <= time_r + 32'd1;
    end
  end

  // Registered interrupt level, built from the current EN and PENDING so
  // both set and clear reach the pin one cycle after the flag changes.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      irq_out_r <= 1'b0;
    end else begin
      irq_out_r <= en_r & pending_r;
    end
  end

  // Read data register: captured on a read strobe, held otherwise.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rdata_r <= '0;
    end else if (bus.slv_reg_rden) begin
      rdata_r <= rdata_s;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign bus.reg_data_out = rdata_r;
  assign IRQ_OUT          = irq_out_r;
  assign IRQ_EVENT_CNT    = evt_cnt_r;

endmodule

// File: tb/tb_san_irq_capture.sv
// -----------------------------------------------------------------------------
// tb_san_irq_capture
//   Self-checking bench: a behavioural model of the register block is stepped
//   on every rising clock edge from the same inputs the DUT sees, and a
//   compare process checks IRQ_OUT, reg_data_out and IRQ_EVENT_CNT against it
//   on every falling edge. Directed scenarios add literal expectations, then
//   a randomized phase exercises arbitrary interleavings.
//   MISSED is built narrow here so saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_san_irq_capture;
  localparam int MW   = 6;
  localparam int MMAX = (1 << MW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext;
  logic        irq_out;
  logic [31:0] evt_mirror;

  san_irq_capture_if bus_if();

  san_irq_capture #(
    .C_S_AXI_DATA_WIDTH(32),
    .MISSED_W(MW)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .EXT_IRQ      (ext),
    .bus          (bus_if),
    .IRQ_OUT      (irq_out),
    .IRQ_EVENT_CNT(evt_mirror)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit          m_valid = 1'b0;
  bit          m_en, m_pend, m_ovf, m_prev, m_irq;
  logic [31:0] m_evt, m_ts, m_time, m_rdata;
  int          m_missed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_reg(input logic [2:0] a);
    case (a)
      3'd0:    return {31'd0, m_en};
      3'd1:    return {30'd0, m_ovf, m_pend};
      3'd2:    return m_evt;
      3'd3:    return 32'(m_missed);
      3'd4:    return m_ts;
      3'd5:    return m_time;
      default: return 32'd0;
    endcase
  endfunction

  // One clock of the register block, expressed as the rules read in order:
  // read old values, apply clears, then apply any accepted edge.
  task automatic model_step();
    bit edge_seen;
    bit accept;
    if (rst) begin
      m_valid = 1'b1;
      m_en = 0; m_pend = 0; m_ovf = 0; m_prev = 0; m_irq = 0;
      m_evt = 0; m_ts = 0; m_time = 0; m_rdata = 0; m_missed = 0;
      return;
    end
    if (bus_if.slv_reg_rden) m_rdata = m_reg(bus_if.axi_araddr);
    m_irq     = m_en & m_pend;
    edge_seen = ext & ~m_prev;
    accept    = edge_seen & m_en;
    if (bus_if.slv_reg_wren && bus_if.axi_awaddr == 3'd1) begin
      if (bus_if.S_AXI_WDATA[0]) m_pend = 1'b0;
      if (bus_if.S_AXI_WDATA[1]) m_ovf = 1'b0;
    end
    if (bus_if.slv_reg_wren && bus_if.axi_awaddr == 3'd0 && bus_if.S_AXI_WDATA[1]) begin
      m_evt    = 0;
      m_missed = 0;
    end
    if (accept) begin
      m_evt = m_evt + 32'd1;
      if (!m_pend) begin
        m_pend = 1'b1;
        m_ts   = m_time;
      end else begin
        if (m_missed < MMAX) m_missed = m_missed + 1;
        if (m_missed == MMAX) m_ovf = 1'b1;
      end
    end
    if (bus_if.slv_reg_wren && bus_if.axi_awaddr == 3'd0) m_en = bus_if.S_AXI_WDATA[0];
    m_time = m_time + 32'd1;
    m_prev = ext;
  endtask

  // Compare process: every falling edge once the model has seen a reset.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("irq_out", {31'd0, irq_out}, {31'd0, m_irq});
        chk("reg_data_out", bus_if.reg_data_out, m_rdata);
        chk("irq_event_cnt", evt_mirror, m_evt);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus_if.slv_reg_wren = 1'b1;
    bus_if.axi_awaddr   = a;
    bus_if.S_AXI_WDATA  = d;
    cyc();
    bus_if.slv_reg_wren = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input string name, input logic [31:0] exp);
    bus_if.slv_reg_rden = 1'b1;
    bus_if.axi_araddr   = a;
    cyc();
    bus_if.slv_reg_rden = 1'b0;
    chk(name, bus_if.reg_data_out, exp);
  endtask

  task automatic pulse();
    ext = 1'b1;
    cyc();
    ext = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    ext = 1'b0;
    bus_if.slv_reg_wren = 1'b0;
    bus_if.axi_awaddr   = 3'd0;
    bus_if.S_AXI_WDATA  = 32'd0;
    bus_if.slv_reg_rden = 1'b0;
    bus_if.axi_araddr   = 3'd0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("reset_irq", {31'd0, irq_out}, 32'd0);
    chk("reset_rdata", bus_if.reg_data_out, 32'd0);

    // T1: enable, single pulse
    wr(3'd0, 32'd1);
    ext = 1'b1;
    cyc();
    ext = 1'b0;
    chk("t1_irq_one_cycle", {31'd0, irq_out}, 32'd0);
    cyc();
    chk("t1_irq_rise", {31'd0, irq_out}, 32'd1);
    rd(3'd1, "t1_status", 32'h1);
    rd(3'd2, "t1_evt_cnt", 32'd1);
    rd(3'd4, "t1_last_ts", 32'd1);
    rd(3'd0, "t1_ctrl", 32'd1);

    // T2: W1C PENDING
    wr(3'd1, 32'd1);
    chk("t2_irq_hold", {31'd0, irq_out}, 32'd1);
    cyc();
    chk("t2_irq_fall", {31'd0, irq_out}, 32'd0);
    rd(3'd1, "t2_status", 32'h0);
    rd(3'd2, "t2_evt_cnt", 32'd1);

    // T3: PENDING held, three missed pulses, then edge + W1C together
    pulse();
    repeat (3) pulse();
    rd(3'd2, "t3_evt_cnt", 32'd5);
    rd(3'd3, "t3_missed", 32'd3);
    ext = 1'b1;
    wr(3'd1, 32'd1);
    ext = 1'b0;
    cyc();
    rd(3'd1, "t3_set_wins", 32'h1);
    rd(3'd2, "t3_evt_cnt2", 32'd6);
    rd(3'd3, "t3_missed2", 32'd3);

    // T4: EN=0 drops edges; re-enable re-asserts IRQ_OUT
    wr(3'd0, 32'd0);
    repeat (10) pulse();
    chk("t4_irq_masked", {31'd0, irq_out}, 32'd0);
    rd(3'd2, "t4_evt_cnt", 32'd6);
    rd(3'd3, "t4_missed", 32'd3);
    rd(3'd1, "t4_status", 32'h1);
    wr(3'd0, 32'd1);
    cyc();
    chk("t4_irq_reenable", {31'd0, irq_out}, 32'd1);

    // T5: drive MISSED to saturation
    for (int i = 0; i < MMAX - 1 - 3; i++) pulse();
    rd(3'd3, "t5_missed_max_m1", 32'(MMAX - 1));
    rd(3'd1, "t5_status_no_ovf", 32'h1);
    pulse();
    pulse();
    rd(3'd3, "t5_missed_sat", 32'(MMAX));
    rd(3'd1, "t5_status_ovf", 32'h3);
    pulse();
    rd(3'd3, "t5_missed_hold", 32'(MMAX));
    rd(3'd2, "t5_evt_cnt", 32'(6 + (MMAX - 4) + 3));
    wr(3'd0, 32'd3);
    rd(3'd2, "t5_clr_evt", 32'd0);
    rd(3'd3, "t5_clr_missed", 32'd0);
    rd(3'd0, "t5_ctrl_clr_reads0", 32'd1);
    ext = 1'b1;
    wr(3'd0, 32'd3);
    ext = 1'b0;
    cyc();
    rd(3'd2, "t5_clr_edge_evt", 32'd1);
    rd(3'd3, "t5_clr_edge_missed", 32'd1);
    wr(3'd1, 32'd3);
    rd(3'd1, "t5_status_cleared", 32'h0);

    // T6: reset mid-operation
    pulse();
    pulse();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_irq", {31'd0, irq_out}, 32'd0);
    chk("t6_evt_mirror", evt_mirror, 32'd0);
    chk("t6_rdata", bus_if.reg_data_out, 32'd0);
    rd(3'd5, "t6_time", 32'd0);
    rd(3'd1, "t6_status", 32'd0);
    rd(3'd2, "t6_evt_cnt", 32'd0);
    rd(3'd3, "t6_missed", 32'd0);
    rd(3'd4, "t6_last_ts", 32'd0);
    rd(3'd0, "t6_ctrl", 32'd0);

    // EXT_IRQ high across reset release with EN=0, then enabled while still high
    ext = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    wr(3'd0, 32'd1);
    cyc();
    rd(3'd2, "held_high_no_edge", 32'd0);
    ext = 1'b0;
    cyc();

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 2) == 0) ext = ~ext;
      bus_if.slv_reg_wren = ($urandom_range(0, 7) == 0);
      bus_if.axi_awaddr   = 3'($urandom_range(0, 7));
      bus_if.S_AXI_WDATA  = $urandom;
      if (bus_if.axi_awaddr == 3'd0) begin
        bus_if.S_AXI_WDATA[0] = ($urandom_range(0, 4) != 0);
        bus_if.S_AXI_WDATA[1] = ($urandom_range(0, 9) == 0);
      end
      bus_if.slv_reg_rden = ($urandom_range(0, 1) == 1);
      bus_if.axi_araddr   = 3'($urandom_range(0, 7));
      cyc();
    end
    rst = 1'b0;
    ext = 1'b0;
    bus_if.slv_reg_wren = 1'b0;
    bus_if.slv_reg_rden = 1'b0;
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
